// File: rtl/db_ctrl_seq.sv
// Deblocking-filter CTU phase sequencer with per-phase cycle counts, chroma-skip/bypass modes and stall.
// Optional macro DB_CTRL_ABORT_EN adds abort_i, which returns the sequencer to IDLE without done_o.
module db_ctrl_seq #(
    parameter int unsigned CNT_W     = 9,
    parameter int unsigned LOAD_CYC  = 384,
    parameter int unsigned YVER_CYC  = 132,
    parameter int unsigned YHOR_CYC  = 140,
    parameter int unsigned CVER_CYC  = 68,
    parameter int unsigned CHOR_CYC  = 76,
    parameter int unsigned OUTLT_CYC = 67,
    parameter int unsigned OUT_CYC   = 384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic             stall_i,
`ifdef DB_CTRL_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             done_o,
    output logic             busy_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             isluma_o,
    output logic             isver_o,
    output logic             phase_start_o
);

    // Encoding is fixed: downstream datapath blocks decode state_o directly.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LOAD  = 3'b001,
        YVER  = 3'b011,
        YHOR  = 3'b010,
        CVER  = 3'b110,
        CHOR  = 3'b111,
        OUTLT = 3'b101,
        OUT   = 3'b100
    } state_t;

    state_t           state;
    state_t           next_phase;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;
    logic [1:0]       mode_r;
    logic             abort;

`ifdef DB_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        last_cnt   = '0;
        next_phase = IDLE;
        case (state)
            LOAD: begin
                last_cnt   = CNT_W'(LOAD_CYC);
                next_phase = mode_r[1] ? OUTLT : YVER;
            end
            YVER: begin
                last_cnt   = CNT_W'(YVER_CYC);
                next_phase = YHOR;
            end
            YHOR: begin
                last_cnt   = CNT_W'(YHOR_CYC);
                next_phase = mode_r[0] ? CVER : OUTLT;
            end
            CVER: begin
                last_cnt   = CNT_W'(CVER_CYC);
                next_phase = CHOR;
            end
            CHOR: begin
                last_cnt   = CNT_W'(CHOR_CYC);
                next_phase = OUTLT;
            end
            OUTLT: begin
                last_cnt   = CNT_W'(OUTLT_CYC);
                next_phase = OUT;
            end
            OUT: begin
                last_cnt   = CNT_W'(OUT_CYC);
                next_phase = IDLE;
            end
            default: begin
                last_cnt   = '0;
                next_phase = IDLE;
            end
        endcase
    end

    // Priority outside IDLE: abort, then stall, then phase end / count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_r <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (start_i) begin
                    state  <= LOAD;
                    mode_r <= mode_i;
                end
            end else if (abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (!stall_i) begin
                if (cnt == last_cnt) begin
                    state <= next_phase;
                    cnt   <= '0;
                    if (state == OUT) begin
                        done_o <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign state_o       = state;
    assign cnt_o         = cnt;
    assign busy_o        = (state != IDLE);
    assign isluma_o      = (state == YVER) || (state == YHOR);
    assign isver_o       = (state == YVER) || (state == CVER);
    assign phase_start_o = (cnt == '0) && (state != IDLE);

endmodule

// File: tb/tb_db_ctrl_seq.sv
// Directed bench for db_ctrl_seq: per-CTU vector table plus reset, back-to-back and abort sequences.
module tb_db_ctrl_seq;

    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [1:0]       mode_i;
    logic             stall_i;
`ifdef DB_CTRL_ABORT_EN
    logic             abort_i;
`endif
    logic             done_o;
    logic             busy_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cnt_o;
    logic             isluma_o;
    logic             isver_o;
    logic             phase_start_o;

    int n_chk  = 0;
    int n_fail = 0;

    db_ctrl_seq #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .stall_i      (stall_i),
`ifdef DB_CTRL_ABORT_EN
        .abort_i      (abort_i),
`endif
        .done_o       (done_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .cnt_o        (cnt_o),
        .isluma_o     (isluma_o),
        .isver_o      (isver_o),
        .phase_start_o(phase_start_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] mode_mid;
        int         start_pulse_at;
        int         stall_at;
        int         stall_len;
        int         e_yver;
        int         e_cver;
        int         e_outlt;
        int         e_out;
        int         e_done;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start at cycle 0, then run to the done_o cycle recording the first cycle of each phase.
    task automatic run_ctu(input vec_t v, input string tag);
        int c;
        int t_yv, t_cv, t_ol, t_ot, t_dn;
        logic [2:0]       fs;
        logic [CNT_W-1:0] fc;
        bit dec_err;
        bit exp_luma, exp_ver, exp_ps;
        t_yv = 0; t_cv = 0; t_ol = 0; t_ot = 0; t_dn = 0;
        dec_err = 1'b0; fs = '0; fc = '0;
        mode_i  = v.mode;
        start_i = 1'b1;
        stall_i = 1'b0;
        step();
        c = 1;
        start_i = 1'b0;
        while (c < 3000) begin
            if (c == 1) begin
                check({tag, " state@1"}, 32'(state_o), 32'(3'b001));
                check({tag, " pstart@1"}, 32'(phase_start_o), 32'd1);
            end
            if (state_o == 3'b011 && t_yv == 0) t_yv = c;
            if (state_o == 3'b110 && t_cv == 0) t_cv = c;
            if (state_o == 3'b101 && t_ol == 0) t_ol = c;
            if (state_o == 3'b100 && t_ot == 0) t_ot = c;
            exp_luma = (state_o == 3'b011) || (state_o == 3'b010);
            exp_ver  = (state_o == 3'b011) || (state_o == 3'b110);
            exp_ps   = (cnt_o == '0) && (state_o != 3'b000);
            if (isluma_o !== exp_luma || isver_o !== exp_ver || phase_start_o !== exp_ps
                || busy_o !== (state_o != 3'b000))
                dec_err = 1'b1;
            if (v.stall_len > 0 && c == v.stall_at) begin
                fs = state_o;
                fc = cnt_o;
            end
            if (v.stall_len > 0 && c == v.stall_at + v.stall_len) begin
                check({tag, " stall state"}, 32'(state_o), 32'(fs));
                check({tag, " stall cnt"}, 32'(cnt_o), 32'(fc));
            end
            if (done_o === 1'b1) begin
                t_dn = c;
                break;
            end
            mode_i  = (c >= 2) ? v.mode_mid : v.mode;
            start_i = (c == v.start_pulse_at);
            stall_i = (v.stall_len > 0 && c >= v.stall_at && c < v.stall_at + v.stall_len);
            step();
            c++;
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        check({tag, " t_yver"}, 32'(t_yv), 32'(v.e_yver));
        check({tag, " t_cver"}, 32'(t_cv), 32'(v.e_cver));
        check({tag, " t_outlt"}, 32'(t_ol), 32'(v.e_outlt));
        check({tag, " t_out"}, 32'(t_ot), 32'(v.e_out));
        check({tag, " t_done"}, 32'(t_dn), 32'(v.e_done));
        check({tag, " decode"}, 32'(dec_err), 32'd0);
        check({tag, " idle@done"}, 32'(state_o), 32'd0);
    endtask

    initial begin
        int k;
        int pulses;
        bit idle_err;
        //          mode   mid    pulse stall len  yver cver outlt out  done
        vecs[0] = '{2'b01, 2'b01, 0,    0,    0,   386, 660, 806,  874, 1259};
        vecs[1] = '{2'b00, 2'b00, 0,    0,    0,   386, 0,   660,  728, 1113};
        vecs[2] = '{2'b10, 2'b10, 0,    0,    0,   0,   0,   386,  454, 839};
        vecs[3] = '{2'b11, 2'b11, 0,    0,    0,   0,   0,   386,  454, 839};
        vecs[4] = '{2'b01, 2'b01, 0,    400,  10,  386, 670, 816,  884, 1269};
        vecs[5] = '{2'b00, 2'b11, 300,  0,    0,   386, 0,   660,  728, 1113};
        vecs[6] = '{2'b11, 2'b01, 500,  0,    0,   0,   0,   386,  454, 839};
        vecs[7] = '{2'b10, 2'b10, 0,    838,  3,   0,   0,   386,  454, 842};

        rst = 1'b1; start_i = 1'b0; mode_i = 2'b00; stall_i = 1'b0;
`ifdef DB_CTRL_ABORT_EN
        abort_i = 1'b0;
`endif
        step(); step();
        check("rst state", 32'(state_o), 32'd0);
        check("rst cnt", 32'(cnt_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst pstart", 32'(phase_start_o), 32'd0);
        rst = 1'b0;

        // Stall in IDLE has no effect, and does not block a start.
        stall_i = 1'b1;
        repeat (5) step();
        check("idle stall state", 32'(state_o), 32'd0);
        check("idle stall cnt", 32'(cnt_o), 32'd0);
        start_i = 1'b1; mode_i = 2'b01;
        step();
        start_i = 1'b0;
        check("start under stall", 32'(state_o), 32'(3'b001));
        step();
        check("stall hold LOAD cnt", 32'(cnt_o), 32'd0);
        stall_i = 1'b0;
        step();
        check("LOAD cnt resumes", 32'(cnt_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst mid-LOAD state", 32'(state_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_ctu(vecs[i], $sformatf("vec%0d", i));
            step();
            check($sformatf("vec%0d done width", i), 32'(done_o), 32'd0);
        end

        // Back-to-back: start held during the done_o cycle.
        run_ctu(vecs[0], "b2b first");
        start_i = 1'b1; mode_i = 2'b01;
        step();
        start_i = 1'b0;
        check("b2b LOAD", 32'(state_o), 32'(3'b001));
        check("b2b done low", 32'(done_o), 32'd0);
        k = 1;
        while (done_o !== 1'b1 && k < 1400) begin
            step();
            k++;
        end
        check("b2b spacing", 32'(k), 32'd1259);

        // Reset mid-CHOR aborts with no done_o.
        step();
        start_i = 1'b1; mode_i = 2'b01;
        step();
        start_i = 1'b0;
        k = 0;
        while (state_o !== 3'b111 && k < 1000) begin
            step();
            k++;
        end
        check("reach CHOR", 32'(state_o), 32'(3'b111));
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst CHOR state", 32'(state_o), 32'd0);
        check("rst CHOR cnt", 32'(cnt_o), 32'd0);
        check("rst CHOR done", 32'(done_o), 32'd0);
        check("rst CHOR busy", 32'(busy_o), 32'd0);
        pulses = 0; idle_err = 1'b0;
        repeat (600) begin
            step();
            if (done_o === 1'b1) pulses++;
            if (state_o !== 3'b000) idle_err = 1'b1;
        end
        check("rst CHOR no done", 32'(pulses), 32'd0);
        check("rst CHOR stays idle", 32'(idle_err), 32'd0);

`ifdef DB_CTRL_ABORT_EN
        start_i = 1'b1; mode_i = 2'b10;
        step();
        start_i = 1'b0;
        k = 0;
        while (state_o !== 3'b100 && k < 1000) begin
            step();
            k++;
        end
        check("reach OUT", 32'(state_o), 32'(3'b100));
        repeat (10) step();
        abort_i = 1'b1; stall_i = 1'b1;
        step();
        abort_i = 1'b0; stall_i = 1'b0;
        check("abort state", 32'(state_o), 32'd0);
        check("abort cnt", 32'(cnt_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        pulses = 0;
        repeat (400) begin
            step();
            if (done_o === 1'b1) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0);
        abort_i = 1'b1; start_i = 1'b1; mode_i = 2'b01;
        step();
        start_i = 1'b0;
        check("start beats abort", 32'(state_o), 32'(3'b001));
        step();
        abort_i = 1'b0;
        check("abort from LOAD", 32'(state_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
